// File: rtl/hazard_pkg.sv
// Shared definitions for the IF/ID sequencing controller: FSM encodings,
// the x0 register index and the legal bubble/flush cycle limits.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BUBBLE  = 2'd1,
    FLUSH   = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         MAX_BUBBLES = 3;
  localparam int         MAX_FLUSH   = 3;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use check: the instruction entering decode reads a
// register that the load currently in ID is about to write (x0 never hazards).
module load_use_detect
  import hazard_pkg::*;
(
  input  logic       i_load_id,
  input  logic [4:0] i_write_reg_id,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic       i_use_rs1,
  input  logic       i_use_rs2,
  output logic       o_hazard
);

  logic w_rs1_match;
  logic w_rs2_match;

  assign w_rs1_match = i_use_rs1 & (i_rs1 == i_write_reg_id);
  assign w_rs2_match = i_use_rs2 & (i_rs2 == i_write_reg_id);
  assign o_hazard    = i_load_id & (i_write_reg_id != REG_ZERO) & (w_rs1_match | w_rs2_match);

endmodule

// File: rtl/hazard_ctrl.sv
// IF/ID sequencing controller: freeze on miss, squash on redirect, bubble on
// load-use. Perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hit,
  input  logic [4:0]       rs1_IF,
  input  logic [4:0]       rs2_IF,
  input  logic             use_rs1_IF,
  input  logic             use_rs2_IF,
  input  logic             load_ID,
  input  logic [4:0]       WriteReg_ID,
  input  logic             redirect_EX,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             Discard_IF,
  output logic             Discard_ID,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] freeze_count
);

  // Out-of-range parameters are clamped into 1..MAX so the 2-bit counter stays valid
  localparam int LB_EFF = (LOAD_BUBBLES > MAX_BUBBLES) ? MAX_BUBBLES :
                          (LOAD_BUBBLES < 1) ? 1 : LOAD_BUBBLES;
  localparam int FC_EFF = (FLUSH_CYCLES > MAX_FLUSH) ? MAX_FLUSH :
                          (FLUSH_CYCLES < 1) ? 1 : FLUSH_CYCLES;
  localparam logic [1:0] BUBBLE_RELOAD = 2'(LB_EFF - 1);
  localparam logic [1:0] FLUSH_RELOAD  = 2'(FC_EFF - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_remaining;
  logic [1:0] w_next_remaining;
  logic       w_hazard;

  load_use_detect u_detect (
    .i_load_id      (load_ID),
    .i_write_reg_id (WriteReg_ID),
    .i_rs1          (rs1_IF),
    .i_rs2          (rs2_IF),
    .i_use_rs1      (use_rs1_IF),
    .i_use_rs2      (use_rs2_IF),
    .o_hazard       (w_hazard)
  );

  assign state = r_state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= RUN;
      r_remaining <= 2'd0;
    end else begin
      r_state     <= w_next_state;
      r_remaining <= w_next_remaining;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_next_remaining = r_remaining;
    PCWrite          = 1'b1;
    IFIDWrite        = 1'b1;
    Discard_IF       = 1'b0;
    Discard_ID       = 1'b0;
    if (!reset) begin
      w_next_state     = RUN;
      w_next_remaining = 2'd0;
    end else if (!hit) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (redirect_EX) begin
      Discard_IF = 1'b1;
      Discard_ID = 1'b1;
      if (FC_EFF > 1) begin
        w_next_state     = FLUSH;
        w_next_remaining = FLUSH_RELOAD;
      end else begin
        w_next_state     = RUN;
        w_next_remaining = 2'd0;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (w_hazard) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            Discard_ID = 1'b1;
            if (LB_EFF > 1) begin
              w_next_state     = BUBBLE;
              w_next_remaining = BUBBLE_RELOAD;
            end else begin
              w_next_state     = RUN;
              w_next_remaining = 2'd0;
            end
          end else begin
            w_next_state = RUN;
          end
        end
        BUBBLE: begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          Discard_ID = 1'b1;
          if (r_remaining <= 2'd1) begin
            w_next_state     = RUN;
            w_next_remaining = 2'd0;
          end else begin
            w_next_remaining = r_remaining - 2'd1;
          end
        end
        FLUSH: begin
          Discard_IF = 1'b1;
          Discard_ID = 1'b1;
          if (r_remaining <= 2'd1) begin
            w_next_state     = RUN;
            w_next_remaining = 2'd0;
          end else begin
            w_next_remaining = r_remaining - 2'd1;
          end
        end
        default: begin
          w_next_state     = RUN;
          w_next_remaining = 2'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic             w_freeze_inc;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;
  logic [CNT_W-1:0] r_freeze_count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign w_freeze_inc = reset & ~hit;
  assign w_flush_inc  = reset & hit & redirect_EX;
  assign w_stall_inc  = reset & hit & ~redirect_EX &
                        (((r_state == RUN) & w_hazard) | (r_state == BUBBLE));

  // Saturating event counters
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stall_count  <= '0;
      r_flush_count  <= '0;
      r_freeze_count <= '0;
    end else begin
      r_stall_count  <= w_stall_inc  ? sat_inc(r_stall_count)  : r_stall_count;
      r_flush_count  <= w_flush_inc  ? sat_inc(r_flush_count)  : r_flush_count;
      r_freeze_count <= w_freeze_inc ? sat_inc(r_freeze_count) : r_freeze_count;
    end
  end

  assign stall_count  = r_stall_count;
  assign flush_count  = r_flush_count;
  assign freeze_count = r_freeze_count;
`else
  assign stall_count  = '0;
  assign flush_count  = '0;
  assign freeze_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench: two controller configurations driven in lockstep
// and compared every cycle against a cycle-count reference model.
module tb_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       hit;
  logic [4:0] rs1_IF, rs2_IF, WriteReg_ID;
  logic       use_rs1_IF, use_rs2_IF, load_ID, redirect_EX;

  logic        pc_a, ifid_a, dif_a, did_a, pc_b, ifid_b, dif_b, did_b;
  logic [1:0]  st_a, st_b;
  logic [15:0] stall_a, flush_a, freeze_a;
  logic [3:0]  stall_b, flush_b, freeze_b;

  always #5 clock = ~clock;

  hazard_ctrl #(.LOAD_BUBBLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .hit(hit), .rs1_IF(rs1_IF), .rs2_IF(rs2_IF),
    .use_rs1_IF(use_rs1_IF), .use_rs2_IF(use_rs2_IF), .load_ID(load_ID),
    .WriteReg_ID(WriteReg_ID), .redirect_EX(redirect_EX),
    .PCWrite(pc_a), .IFIDWrite(ifid_a), .Discard_IF(dif_a), .Discard_ID(did_a),
    .state(st_a), .stall_count(stall_a), .flush_count(flush_a), .freeze_count(freeze_a));

  hazard_ctrl #(.LOAD_BUBBLES(3), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .hit(hit), .rs1_IF(rs1_IF), .rs2_IF(rs2_IF),
    .use_rs1_IF(use_rs1_IF), .use_rs2_IF(use_rs2_IF), .load_ID(load_ID),
    .WriteReg_ID(WriteReg_ID), .redirect_EX(redirect_EX),
    .PCWrite(pc_b), .IFIDWrite(ifid_b), .Discard_IF(dif_b), .Discard_ID(did_b),
    .state(st_b), .stall_count(stall_b), .flush_count(flush_b), .freeze_count(freeze_b));

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: pending bubble/flush cycles and event totals per configuration
  int cfg_lb[2]  = '{1, 3};
  int cfg_fc[2]  = '{1, 3};
  int cfg_max[2] = '{65535, 15};
  int m_stall_left[2], m_flush_left[2], m_stall[2], m_flush[2], m_freeze[2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  function automatic int perf(input int v);
`ifdef HAZARD_PERF_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic step(input logic rst, input logic h, input logic [4:0] r1, input logic [4:0] r2,
                      input logic u1, input logic u2, input logic ld, input logic [4:0] wr,
                      input logic rd);
    logic [3:0] exp_ctl, obs_ctl;
    logic [1:0] obs_st;
    int obs_s, obs_f, obs_z, exp_st;
    bit haz;
    @(negedge clock);
    reset = rst; hit = h; rs1_IF = r1; rs2_IF = r2; use_rs1_IF = u1; use_rs2_IF = u2;
    load_ID = ld; WriteReg_ID = wr; redirect_EX = rd;
    #1;
    haz = ld && (wr != 5'd0) && ((u1 && r1 == wr) || (u2 && r2 == wr));
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        obs_ctl = {pc_a, ifid_a, dif_a, did_a}; obs_st = st_a;
        obs_s = int'(stall_a); obs_f = int'(flush_a); obs_z = int'(freeze_a);
      end else begin
        obs_ctl = {pc_b, ifid_b, dif_b, did_b}; obs_st = st_b;
        obs_s = int'(stall_b); obs_f = int'(flush_b); obs_z = int'(freeze_b);
      end
      exp_st = (m_flush_left[d] > 0) ? 2 : (m_stall_left[d] > 0) ? 1 : 0;
      check_val($sformatf("state%0d", d), {30'd0, obs_st}, exp_st);
      check_val($sformatf("stall_count%0d", d), obs_s, perf(m_stall[d]));
      check_val($sformatf("flush_count%0d", d), obs_f, perf(m_flush[d]));
      check_val($sformatf("freeze_count%0d", d), obs_z, perf(m_freeze[d]));
      // exp_ctl = {PCWrite, IFIDWrite, Discard_IF, Discard_ID}
      if (!rst) begin
        exp_ctl = 4'b1100;
        m_stall_left[d] = 0; m_flush_left[d] = 0;
        m_stall[d] = 0; m_flush[d] = 0; m_freeze[d] = 0;
      end else if (!h) begin
        exp_ctl = 4'b0000;
        m_freeze[d] = sat(m_freeze[d], cfg_max[d]);
      end else if (rd) begin
        exp_ctl = 4'b1111;
        m_flush_left[d] = cfg_fc[d] - 1; m_stall_left[d] = 0;
        m_flush[d] = sat(m_flush[d], cfg_max[d]);
      end else if (m_flush_left[d] > 0) begin
        exp_ctl = 4'b1111;
        m_flush_left[d]--;
      end else if (m_stall_left[d] > 0) begin
        exp_ctl = 4'b0001;
        m_stall_left[d]--;
        m_stall[d] = sat(m_stall[d], cfg_max[d]);
      end else if (haz) begin
        exp_ctl = 4'b0001;
        m_stall_left[d] = cfg_lb[d] - 1;
        m_stall[d] = sat(m_stall[d], cfg_max[d]);
      end else begin
        exp_ctl = 4'b1100;
      end
      check_val($sformatf("ctl%0d", d), {28'd0, obs_ctl}, {28'd0, exp_ctl});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_stall_left[d] = 0; m_flush_left[d] = 0;
      m_stall[d] = 0; m_flush[d] = 0; m_freeze[d] = 0;
    end
    reset = 1'b0; hit = 1'b1; rs1_IF = 5'd0; rs2_IF = 5'd0; use_rs1_IF = 1'b0;
    use_rs2_IF = 1'b0; load_ID = 1'b0; WriteReg_ID = 5'd0; redirect_EX = 1'b0;
    do_reset(2);
    idle(2);

    // lw x5 in ID, consumer reads rs1=x5
    step(1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0);
    idle(4);

    // x0 destination never stalls
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
    idle(2);

    // rs2 hazard, then redirect on the second bubble cycle
    step(1'b1, 1'b1, 5'd1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
    step(1'b1, 1'b1, 5'd1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
    idle(4);

    // redirect, then a miss during the flush window
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1);
    idle(4);

    // reset in the middle of a bubble sequence
    step(1'b1, 1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0);
    do_reset(1);
    idle(2);

    // 20 consecutive hazard cycles drive the 4-bit stall counter into saturation
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
